// File: rtl/lsu_seq_pkg.sv
// Shared types and constants for the LSU instruction sequencer.
package lsu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_MEM = 2'd2,
    DONE     = 2'd3
  } seq_state_e;

  typedef enum logic {
    MEM_LOAD  = 1'b0,
    MEM_STORE = 1'b1
  } mem_kind_e;

  localparam logic [6:0]  OPC_LOAD  = 7'b0000011;
  localparam logic [6:0]  OPC_STORE = 7'b0100011;
  localparam logic [31:0] INSTR_NOP = 32'h00000013;

  // Major opcode field of an RV32 instruction word.
  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/lsu_seq_prog_mem.sv
// Program store: PROG_DEPTH x 32 registers, async read, gated write, reset to NOP.
module lsu_seq_prog_mem
  import lsu_seq_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 8,
  localparam int unsigned AW        = $clog2(PROG_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [PROG_DEPTH-1:0][31:0] mem;

  // Every entry comes back as a NOP after reset; writes are gated by the caller.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem <= {PROG_DEPTH{INSTR_NOP}};
    end else if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/lsu_instr_sequencer.sv
// Feeds a stored program into the core shim, stalling after each load/store
// until its memory response (or the watchdog) releases the sequencer.
module lsu_instr_sequencer
  import lsu_seq_pkg::*;
#(
  parameter int unsigned PROG_DEPTH    = 8,
  parameter int unsigned STALL_TIMEOUT = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          prog_we_i,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr_i,
  input  logic [31:0]                   prog_data_i,
  input  logic [$clog2(PROG_DEPTH):0]   prog_len_i,
  input  logic                          start_i,
  output logic [31:0]                   instr_o,
  output logic                          instr_valid_o,
  input  logic                          instr_ready_i,
  input  logic                          load_mem_resp_i,
  input  logic                          store_mem_resp_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          timeout_o,
  output logic [$clog2(PROG_DEPTH):0]   issued_cnt_o
);

  localparam int unsigned AW = $clog2(PROG_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(STALL_TIMEOUT + 1);

  seq_state_e    state;
  mem_kind_e     exp_kind;
  logic [CW-1:0] pc;
  logic [CW-1:0] len;
  logic [CW-1:0] issued_cnt;
  logic [WW-1:0] wdog;
  logic          timeout_q;

  logic          busy;
  logic          prog_we;
  logic [31:0]   rd_instr;
  logic [CW-1:0] len_clamped;
  logic          resp_match;
  logic          wdog_expired;
  logic [6:0]    opc;

  assign busy    = (state == ISSUE) || (state == WAIT_MEM);
  assign prog_we = prog_we_i && !busy;

  lsu_seq_prog_mem #(
    .PROG_DEPTH(PROG_DEPTH)
  ) u_prog_mem (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .we_i   (prog_we),
    .waddr_i(prog_addr_i),
    .wdata_i(prog_data_i),
    .raddr_i(pc[AW-1:0]),
    .rdata_o(rd_instr)
  );

  // Lengths past the store size are clamped so pc never wraps.
  assign len_clamped = (prog_len_i > CW'(PROG_DEPTH)) ? CW'(PROG_DEPTH) : prog_len_i;

  // Only the response of the expected kind can release WAIT_MEM.
  assign resp_match   = (exp_kind == MEM_LOAD) ? load_mem_resp_i : store_mem_resp_i;
  assign wdog_expired = (wdog == WW'(STALL_TIMEOUT - 1));
  assign opc          = opcode_of(rd_instr);

  // Sequencer FSM with program counter, issue counter and watchdog.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      exp_kind   <= MEM_LOAD;
      pc         <= '0;
      len        <= '0;
      issued_cnt <= '0;
      wdog       <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            pc         <= '0;
            issued_cnt <= '0;
            timeout_q  <= 1'b0;
            wdog       <= '0;
            len        <= len_clamped;
            state      <= (len_clamped == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready_i) begin
            pc         <= pc + CW'(1);
            issued_cnt <= issued_cnt + CW'(1);
            wdog       <= '0;
            if (opc == OPC_LOAD) begin
              exp_kind <= MEM_LOAD;
              state    <= WAIT_MEM;
            end else if (opc == OPC_STORE) begin
              exp_kind <= MEM_STORE;
              state    <= WAIT_MEM;
            end else if (pc + CW'(1) == len) begin
              state    <= DONE;
            end
          end
        end
        WAIT_MEM: begin
          // A matching response on the expiry edge wins over the watchdog.
          if (resp_match || wdog_expired) begin
            if (!resp_match) timeout_q <= 1'b1;
            state <= (pc == len) ? DONE : ISSUE;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only.
  assign instr_valid_o = (state == ISSUE);
  assign instr_o       = (state == ISSUE) ? rd_instr : 32'h0;
  assign busy_o        = busy;
  assign done_o        = (state == DONE);
  assign timeout_o     = timeout_q;
  assign issued_cnt_o  = issued_cnt;

endmodule

// File: tb/tb_lsu_instr_sequencer.sv
// Self-checking bench for lsu_instr_sequencer: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_lsu_instr_sequencer;
  import lsu_seq_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [2:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [3:0]  prog_len = '0;
  logic        start = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        load_resp = 1'b0;
  logic        store_resp = 1'b0;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [3:0]  issued_cnt;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] prog_m [DEPTH];

  always #5 clk = ~clk;

  lsu_instr_sequencer #(.PROG_DEPTH(DEPTH), .STALL_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data),
    .prog_len_i(prog_len), .start_i(start),
    .instr_o(instr), .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .load_mem_resp_i(load_resp), .store_mem_resp_i(store_resp),
    .busy_o(busy), .done_o(done), .timeout_o(timeout), .issued_cnt_o(issued_cnt)
  );

  function automatic logic [31:0] mk_addi(input int rd, input int imm);
    return {12'(imm), 5'd0, 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] mk_lw(input int rd);
    return {12'h004, 5'd1, 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] mk_sw(input int rs);
    return {7'h0, 5'(rs), 5'd1, 3'b010, 5'h8, 7'b0100011};
  endfunction

  // Program write while idle; the model follows.
  task automatic wr(input int a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = 3'(a); prog_data = d; prog_m[a] = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Start pulse; returns at the negedge of the first cycle after start.
  task automatic go(input int len, input logic rdy);
    start = 1'b1; prog_len = 4'(len); instr_ready = rdy;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", instr_valid); else n_pass++;
    n_chk++; if (instr !== 32'h0) $display("FAIL reset_instr got %h exp 0", instr); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_chk++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b exp 0", timeout); else n_pass++;
    n_chk++; if (issued_cnt !== 4'd0) $display("FAIL reset_cnt got %0d exp 0", issued_cnt); else n_pass++;
  endtask

  task automatic test_alu_stream();
    wr(0, mk_addi(1, 11));
    wr(1, mk_addi(2, 22));
    // last write lands together with start: run must see it
    prog_we = 1'b1; prog_addr = 3'd2; prog_data = mk_addi(3, 33); prog_m[2] = mk_addi(3, 33);
    go(3, 1'b1);
    prog_we = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_chk++; if (instr_valid !== 1'b1) $display("FAIL alu_valid c%0d got %b exp 1", c, instr_valid); else n_pass++;
      n_chk++; if (instr !== prog_m[c-1]) $display("FAIL alu_instr c%0d got %h exp %h", c, instr, prog_m[c-1]); else n_pass++;
      n_chk++; if (issued_cnt !== 4'(c-1)) $display("FAIL alu_cnt c%0d got %0d exp %0d", c, issued_cnt, c-1); else n_pass++;
      @(negedge clk);
    end
    n_chk++; if (done !== 1'b1) $display("FAIL alu_done got %b exp 1", done); else n_pass++;
    n_chk++; if (instr_valid !== 1'b0 || busy !== 1'b0) $display("FAIL alu_end_valid_busy got %b%b exp 00", instr_valid, busy); else n_pass++;
    n_chk++; if (issued_cnt !== 4'd3) $display("FAIL alu_end_cnt got %0d exp 3", issued_cnt); else n_pass++;
  endtask

  task automatic test_mem_wait();
    bit ev [1:7] = '{1, 1, 0, 0, 1, 0, 1};
    int ix [1:7] = '{0, 1, 0, 0, 2, 0, 3};
    int ec [1:7] = '{0, 1, 2, 2, 2, 3, 3};
    logic [31:0] e;
    wr(0, mk_addi(4, 1)); wr(1, mk_sw(4)); wr(2, mk_lw(5)); wr(3, mk_addi(6, 2));
    go(4, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      e = ev[c] ? prog_m[ix[c]] : 32'h0;
      n_chk++; if (instr_valid !== ev[c]) $display("FAIL mem_valid c%0d got %b exp %b", c, instr_valid, ev[c]); else n_pass++;
      n_chk++; if (instr !== e) $display("FAIL mem_instr c%0d got %h exp %h", c, instr, e); else n_pass++;
      n_chk++; if (issued_cnt !== 4'(ec[c])) $display("FAIL mem_cnt c%0d got %0d exp %0d", c, issued_cnt, ec[c]); else n_pass++;
      store_resp = (c == 4);
      load_resp  = (c == 3) || (c == 6);
      @(negedge clk);
    end
    store_resp = 1'b0; load_resp = 1'b0;
    n_chk++; if (done !== 1'b1) $display("FAIL mem_done got %b exp 1", done); else n_pass++;
    n_chk++; if (issued_cnt !== 4'd4) $display("FAIL mem_end_cnt got %0d exp 4", issued_cnt); else n_pass++;
    n_chk++; if (timeout !== 1'b0) $display("FAIL mem_timeout got %b exp 0", timeout); else n_pass++;
  endtask

  task automatic test_timeout();
    bit ev  [1:6] = '{1, 0, 0, 0, 0, 1};
    bit eto [1:6] = '{0, 0, 0, 0, 0, 1};
    int ec  [1:6] = '{0, 1, 1, 1, 1, 1};
    wr(0, mk_sw(7)); wr(1, mk_addi(8, 3));
    go(2, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      n_chk++; if (instr_valid !== ev[c]) $display("FAIL tmo_valid c%0d got %b exp %b", c, instr_valid, ev[c]); else n_pass++;
      n_chk++; if (timeout !== eto[c]) $display("FAIL tmo_flag c%0d got %b exp %b", c, timeout, eto[c]); else n_pass++;
      n_chk++; if (issued_cnt !== 4'(ec[c])) $display("FAIL tmo_cnt c%0d got %0d exp %0d", c, issued_cnt, ec[c]); else n_pass++;
      store_resp = (c == 1);               // accept-cycle response must not count
      load_resp  = (c == 2) || (c == 3);   // wrong kind, ignored
      @(negedge clk);
    end
    store_resp = 1'b0; load_resp = 1'b0;
    n_chk++; if (done !== 1'b1) $display("FAIL tmo_done got %b exp 1", done); else n_pass++;
    n_chk++; if (timeout !== 1'b1) $display("FAIL tmo_sticky got %b exp 1", timeout); else n_pass++;
    n_chk++; if (issued_cnt !== 4'd2) $display("FAIL tmo_end_cnt got %0d exp 2", issued_cnt); else n_pass++;
  endtask

  task automatic test_zero_len();
    go(0, 1'b1);
    n_chk++; if (done !== 1'b1) $display("FAIL zero_done got %b exp 1", done); else n_pass++;
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL zero_valid got %b exp 0", instr_valid); else n_pass++;
    n_chk++; if (timeout !== 1'b0) $display("FAIL zero_timeout_cleared got %b exp 0", timeout); else n_pass++;
    n_chk++; if (issued_cnt !== 4'd0) $display("FAIL zero_cnt got %0d exp 0", issued_cnt); else n_pass++;
    @(negedge clk);
    n_chk++; if (instr_valid !== 1'b0 || done !== 1'b1) $display("FAIL zero_hold got v%b d%b exp v0 d1", instr_valid, done); else n_pass++;
  endtask

  task automatic test_ready_stall();
    wr(0, mk_addi(9, 5)); wr(1, mk_addi(10, 6));
    go(2, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      n_chk++; if (instr_valid !== 1'b1) $display("FAIL stall_valid c%0d got %b exp 1", c, instr_valid); else n_pass++;
      n_chk++; if (instr !== prog_m[0]) $display("FAIL stall_instr c%0d got %h exp %h", c, instr, prog_m[0]); else n_pass++;
      n_chk++; if (issued_cnt !== 4'd0) $display("FAIL stall_cnt c%0d got %0d exp 0", c, issued_cnt); else n_pass++;
      instr_ready = (c == 4);
      @(negedge clk);
    end
    n_chk++; if (instr !== prog_m[1]) $display("FAIL stall_next got %h exp %h", instr, prog_m[1]); else n_pass++;
    n_chk++; if (issued_cnt !== 4'd1) $display("FAIL stall_next_cnt got %0d exp 1", issued_cnt); else n_pass++;
    @(negedge clk);
    n_chk++; if (done !== 1'b1 || issued_cnt !== 4'd2) $display("FAIL stall_done got d%b cnt%0d exp d1 cnt2", done, issued_cnt); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    wr(0, mk_lw(11)); wr(1, mk_addi(12, 7));
    go(2, 1'b1);
    @(negedge clk);                       // now waiting for the load
    n_chk++; if (busy !== 1'b1) $display("FAIL rst_busy_wait got %b exp 1", busy); else n_pass++;
    prog_we = 1'b1; prog_addr = 3'd1; prog_data = 32'hdeadbeef;   // dropped
    @(negedge clk);
    prog_we = 1'b0; load_resp = 1'b1;
    @(negedge clk);
    load_resp = 1'b0;
    n_chk++; if (instr !== prog_m[1]) $display("FAIL busy_write_dropped got %h exp %h", instr, prog_m[1]); else n_pass++;
    @(negedge clk);
    n_chk++; if (done !== 1'b1) $display("FAIL rst_prerun_done got %b exp 1", done); else n_pass++;
    go(1, 1'b1);
    @(negedge clk);                       // WAIT_MEM again
    load_resp = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (instr_valid !== 1'b0 || instr !== 32'h0) $display("FAIL rst_mid_instr got v%b %h exp v0 0", instr_valid, instr); else n_pass++;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_state got b%b d%b exp b0 d0", busy, done); else n_pass++;
    n_chk++; if (issued_cnt !== 4'd0 || timeout !== 1'b0) $display("FAIL rst_mid_cnt got %0d t%b exp 0 t0", issued_cnt, timeout); else n_pass++;
    for (int i = 0; i < DEPTH; i++) prog_m[i] = INSTR_NOP;
    @(negedge clk);
    rst_n = 1'b1; load_resp = 1'b0;
    @(negedge clk);
    go(1, 1'b0);
    n_chk++; if (instr !== INSTR_NOP) $display("FAIL rst_prog_nop got %h exp %h", instr, INSTR_NOP); else n_pass++;
    instr_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (done !== 1'b1 || issued_cnt !== 4'd1) $display("FAIL rst_after_run got d%b cnt%0d exp d1 cnt1", done, issued_cnt); else n_pass++;
  endtask

  task automatic test_random();
    int len, len_in, idx, cnt, phase, w, dly, k;
    logic to, kind_load, match, rdy;
    logic [31:0] e, exp_i;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        k = $urandom_range(9, 0);
        if (k < 5)      e = mk_addi(i + 1, $urandom_range(2047, 0));
        else if (k < 7) e = mk_lw(i + 1);
        else if (k < 9) e = mk_sw(i + 1);
        else            e = {$urandom_range(65535, 0), 9'h0, 7'b1100011};
        wr(i, e);
      end
      len_in = $urandom_range(15, 0);
      len = (len_in > DEPTH) ? DEPTH : len_in;
      idx = 0; cnt = 0; to = 1'b0; w = 0; dly = 0; kind_load = 1'b0;
      phase = (len == 0) ? 2 : 0;         // 0 issuing, 1 waiting, 2 done
      go(len_in, $urandom_range(3, 0) != 0);
      for (int cyc = 0; ; cyc++) begin
        if (cyc > 300) begin
          n_chk++; $display("FAIL rand_run%0d no completion within 300 cycles", r);
          break;
        end
        exp_i = 32'h0;
        if (phase == 0) exp_i = prog_m[idx];
        n_chk++; if (instr_valid !== (phase == 0)) $display("FAIL rand_valid r%0d c%0d got %b exp %b", r, cyc, instr_valid, phase == 0); else n_pass++;
        n_chk++; if (instr !== exp_i) $display("FAIL rand_instr r%0d c%0d got %h exp %h", r, cyc, instr, exp_i); else n_pass++;
        n_chk++; if (busy !== (phase != 2) || done !== (phase == 2)) $display("FAIL rand_busy_done r%0d c%0d got b%b d%b exp phase %0d", r, cyc, busy, done, phase); else n_pass++;
        n_chk++; if (issued_cnt !== 4'(cnt)) $display("FAIL rand_cnt r%0d c%0d got %0d exp %0d", r, cyc, issued_cnt, cnt); else n_pass++;
        n_chk++; if (timeout !== to) $display("FAIL rand_timeout r%0d c%0d got %b exp %b", r, cyc, timeout, to); else n_pass++;
        if (phase == 2) break;
        rdy = ($urandom_range(3, 0) != 0);
        match = 1'b0;
        if (phase == 1) begin
          match = (w == dly);
          load_resp  = kind_load ? match : ($urandom_range(2, 0) == 0);
          store_resp = kind_load ? ($urandom_range(2, 0) == 0) : match;
        end else begin
          load_resp  = ($urandom_range(3, 0) == 0);
          store_resp = ($urandom_range(3, 0) == 0);
        end
        instr_ready = rdy;
        prog_we   = ($urandom_range(4, 0) == 0);   // busy: must be dropped
        prog_addr = 3'($urandom_range(7, 0));
        prog_data = $urandom;
        if (phase == 0) begin
          if (rdy) begin
            e = prog_m[idx]; idx++; cnt++;
            if (e[6:0] == OPC_LOAD || e[6:0] == OPC_STORE) begin
              phase = 1; w = 1; kind_load = (e[6:0] == OPC_LOAD);
              dly = $urandom_range(6, 1);
            end else if (idx == len) phase = 2;
          end
        end else begin
          if (match || w == TMO) begin
            if (!match) to = 1'b1;
            phase = (idx == len) ? 2 : 0;
          end else w++;
        end
        @(negedge clk);
      end
      prog_we = 1'b0; load_resp = 1'b0; store_resp = 1'b0; instr_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) prog_m[i] = INSTR_NOP;
    #12 rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_zero_len();
    test_alu_stream();
    test_mem_wait();
    test_timeout();
    test_zero_len();
    test_ready_stall();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/lsu_instr_sequencer.md
# lsu_instr_sequencer

Synthesizable instruction sequencer that feeds a short program into `cva6_processor_shim` over its `instr_i`/`instr_valid_i`/`instr_ready_o` handshake. After issuing a load or store, it holds off further issue until the matching memory response arrives. A watchdog provides the fallback when no response comes. It sits between a program-loading host (bench or debug port) and the shim, and replaces ad-hoc PC/ready bookkeeping in LSU harnesses.

## Interface
Parameters:
- `PROG_DEPTH`, 8: number of program entries (power of two, ≥2).
- `STALL_TIMEOUT`, 16: maximum cycles spent in WAIT_MEM before a forced release (≥1).

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `prog_we_i` in 1: program write strobe.
- `prog_addr_i` in $clog2(PROG_DEPTH): program write index.
- `prog_data_i` in 32: program write data.
- `prog_len_i` in $clog2(PROG_DEPTH)+1: program length, sampled at start.
- `start_i` in 1: start pulse.
- `instr_o` out 32: instruction to the shim.
- `instr_valid_o` out 1: instruction valid to the shim.
- `instr_ready_i` in 1: shim `instr_ready_o`.
- `load_mem_resp_i` in 1: load response.
- `store_mem_resp_i` in 1: store response.
- `busy_o` out 1: sequencer in ISSUE or WAIT_MEM.
- `done_o` out 1: program complete; level output.
- `timeout_o` out 1: sticky flag; set by any watchdog release in the current run.
- `issued_cnt_o` out $clog2(PROG_DEPTH)+1: number of instructions accepted in the current run.

## Operation
States:
- **IDLE**
  - `start_i` with `prog_len_i`≠0 → ISSUE. Latch `len`; clear `pc`, `issued_cnt_o` and `timeout_o`.
  - `start_i` with `prog_len_i`=0 → DONE, with counters cleared.
- **ISSUE**
  - Outputs: `instr_valid_o`=1, `instr_o`=prog[pc].
  - A transfer occurs when valid&&ready. On a transfer: `pc`++, `issued_cnt_o`++. Next state:
    - opcode[6:0]=0000011 → WAIT_MEM, expecting a load.
    - opcode[6:0]=0100011 → WAIT_MEM, expecting a store.
    - otherwise, `pc`+1==`len` → DONE.
    - otherwise → stay in ISSUE.
  - No transfer: hold state and `instr_o` stable.
- **WAIT_MEM**
  - Outputs: `instr_valid_o`=0, `instr_o`=0.
  - Only the response matching the expected type releases the state; the other response is ignored.
  - The watchdog counts cycles in WAIT_MEM. When it reaches `STALL_TIMEOUT` with no matching response, force a release and set `timeout_o`.
  - On release: `pc`==`len` → DONE, else → ISSUE.
- **DONE**
  - `done_o`=1, `busy_o`=0.
  - `start_i` → behaves as `start_i` in IDLE (restart).

Rules:
- Program writes are accepted only when `busy_o`=0; writes while busy are dropped.
- A write and `start_i` in the same cycle: the write lands first, so the run sees the new data.
- `start_i` while busy is ignored.
- `pc` and `len` never wrap: `len` is clamped to `PROG_DEPTH`.
- Reset, including mid-run:
  - State → IDLE; all outputs 0.
  - All program entries → 32'h00000013 (NOP).
  - Watchdog cleared.
  - Any in-flight response is discarded.

## Timing
- `start_i` sampled at edge t → `instr_valid_o` high in cycle t+1.
- ALU instructions with ready held high issue one per cycle, with no bubbles.
- Memory instruction accepted at edge t → WAIT_MEM from t+1. A matching response is sampled at edge t+k (k≥1) → next `instr_valid_o` in cycle t+k+1. A response asserted in the accept cycle itself is not counted.
- Watchdog release occurs at edge t+`STALL_TIMEOUT`, if no response has been sampled by then.
- `done_o` rises in the cycle after the last release or transfer.
- All outputs are registered or decoded purely from state; there is no combinational input → output path.

## Structure
- Package `lsu_seq_pkg` holds:
  - state enum {IDLE, ISSUE, WAIT_MEM, DONE};
  - `OPC_LOAD`=7'b0000011, `OPC_STORE`=7'b0100011, `INSTR_NOP`=32'h00000013;
  - the memory-kind enum {MEM_LOAD, MEM_STORE}.
- Sub-module `lsu_seq_prog_mem`: a `PROG_DEPTH`×32 register array with asynchronous read, a gated write port and reset-to-NOP.
- The FSM, counters and watchdog live in the top module.

## Test plan
- Program [addi, addi, addi], len=3, ready=1 → valid in cycles 1–3 with the entries in order; `done_o` in cycle 4; `issued_cnt_o`=3.
- Program [addi, sw, lw, addi], store response 2 cycles after sw accept, load response 1 cycle after lw accept → sw waits 2 cycles, lw waits 1; `issued_cnt_o`=4; `done_o`=1; `timeout_o`=0.
- sw issued, only `load_mem_resp_i` pulsed, `STALL_TIMEOUT`=4 → load response ignored; release after 4 cycles; `timeout_o`=1; run completes.
- Ready low for 3 cycles during ISSUE → `instr_o` stable, `issued_cnt_o` unchanged; transfer in the cycle ready rises.
- `rst_ni` asserted while in WAIT_MEM → immediately state=IDLE, all outputs 0, prog[0]=32'h00000013; a prog write during busy is dropped.
- `start_i` with `prog_len_i`=0 → `done_o`=1 next cycle, with `instr_valid_o` never asserted.
